mil1553_encoder: RTL

MIL1553_ENCODER -- requirements
Module: mil1553_encoder

---
 rtl/mil1553_encoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mil1553_encoder.sv
// MIL-STD-1553 Manchester II word encoder: sync, 16 data bits and odd parity
// driven onto a differential transceiver pair, with a valid/ready word input.
module mil1553_encoder #(
    parameter int CLOCK_SPEED = 100000000
) (
    input  logic        clk_100mhz,
    input  logic        resetn,
    input  logic [15:0] s_data,
    input  logic        s_cmd,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        diff_pos,
    output logic        diff_neg,
    output logic        tx_active
);

    localparam int HALF_BIT = CLOCK_SPEED / 2000000;
    localparam int HB_W     = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t            state_q, state_d;
    logic [HB_W-1:0]   hb_q, hb_d;
    logic [2:0]        half_q, half_d;
    logic [3:0]        bit_q, bit_d;
    logic [16:0]       sh_q, sh_d;
    logic              cmd_q, cmd_d;
    logic              pos_q, pos_d;
    logic              neg_q, neg_d;
    logic              act_q, act_d;
    logic              hb_last, word_end, xfer, line;

    always_comb begin
        hb_last  = (hb_q == HB_LAST);
        word_end = (state_q == PARITY) && hb_last && (half_q == 3'd1);
        s_ready  = resetn && ((state_q == IDLE) || word_end);
        xfer     = s_valid && s_ready;

        state_d = state_q;
        hb_d    = hb_last ? '0 : hb_q + 1'b1;
        half_d  = half_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cmd_d   = cmd_q;

        unique case (state_q)
            IDLE: hb_d = '0;
            SYNC: begin
                if (hb_last) begin
                    half_d = half_q + 3'd1;
                    if (half_q == 3'd5) begin
                        state_d = DATA;
                        half_d  = 3'd0;
                        bit_d   = 4'd0;
                    end
                end
            end
            DATA: begin
                if (hb_last) begin
                    if (half_q == 3'd0) begin
                        half_d = 3'd1;
                    end else begin
                        half_d = 3'd0;
                        sh_d   = {sh_q[15:0], 1'b0};
                        if (bit_q == 4'd15) state_d = PARITY;
                        else                bit_d   = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (hb_last) begin
                    if (half_q == 3'd0) begin
                        half_d = 3'd1;
                    end else begin
                        state_d = IDLE;
                        half_d  = 3'd0;
                        bit_d   = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer in IDLE or the last parity clock starts a fresh sync.
        if (xfer) begin
            state_d = SYNC;
            hb_d    = '0;
            half_d  = 3'd0;
            bit_d   = 4'd0;
            sh_d    = {s_data, ~^s_data};
            cmd_d   = s_cmd;
        end

        // Line level is computed from the next state so the outputs are plain flops.
        unique case (state_d)
            SYNC:        line = cmd_d ? (half_d < 3'd3) : (half_d >= 3'd3);
            DATA, PARITY: line = sh_d[16] ^ half_d[0];
            default:     line = 1'b0;
        endcase

        act_d = (state_d != IDLE);
        pos_d = line;
        neg_d = act_d & ~line;
    end

    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hb_q    <= '0;
            half_q  <= 3'd0;
            bit_q   <= 4'd0;
            sh_q    <= 17'd0;
            cmd_q   <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cmd_q   <= cmd_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            act_q   <= act_d;
        end
    end

    assign diff_pos  = pos_q;
    assign diff_neg  = neg_q;
    assign tx_active = act_q;

endmodule
